epl_egr_rx: RTL

EPL_EGR_RX -- requirements
Module: epl_egr_rx

---
 rtl/epl_egr_rx_pkg.sv | 27 ++
 rtl/epl_egr_rx_if.sv | 36 +++
 rtl/epl_egr_rx_fifo.sv | 54 +++++
 rtl/epl_egr_rx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/epl_egr_rx_pkg.sv
// Shared types and defaults for the egress receive buffer that sits between
// the credit-governed egress TXC and the MAC.
package epl_egr_rx_pkg;

    localparam int DATA_W_DEF = 512;
    localparam int DEPTH_DEF  = 8;
    localparam int LEN_W_DEF  = $clog2(DATA_W_DEF / 8);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    // One buffered word; the top re-declares this shape at its own DATA_W.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [LEN_W_DEF-1:0]  eop_len;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    // Credits returned in one cycle: pops plus framing drops (0..2).
    function automatic logic [1:0] credit_sum(input logic a, input logic b);
        return 2'(a) + 2'(b);
    endfunction

endpackage

// File: rtl/epl_egr_rx_if.sv
// Egress-side word bus and MAC-side head bus of epl_egr_rx.
interface epl_egr_rx_if
    import epl_egr_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    localparam int LEN_W = $clog2(DATA_W / 8);

    // Egress side has no ready: egr_valid is credit-governed, one credit per
    // word, returned via egr_credit_ret. MAC side: a word transfers on every
    // cycle with mac_valid && mac_ready, and mac_* holds while not accepted.
    logic              egr_valid;
    logic              egr_sop;
    logic              egr_eop;
    logic [DATA_W-1:0] egr_data;
    logic [LEN_W-1:0]  egr_eop_len;
    logic [1:0]        egr_credit_ret;

    logic              mac_valid;
    logic              mac_sop;
    logic              mac_eop;
    logic [DATA_W-1:0] mac_data;
    logic [LEN_W-1:0]  mac_eop_len;
    logic              mac_ready;

    modport master (
        output egr_valid, egr_sop, egr_eop, egr_data, egr_eop_len, mac_ready,
        input  egr_credit_ret, mac_valid, mac_sop, mac_eop, mac_data, mac_eop_len
    );

    modport slave (
        input  egr_valid, egr_sop, egr_eop, egr_data, egr_eop_len, mac_ready,
        output egr_credit_ret, mac_valid, mac_sop, mac_eop, mac_data, mac_eop_len
    );

endinterface

// File: rtl/epl_egr_rx_fifo.sv
// Circular word buffer: register storage, head read straight from storage so a
// word written into an empty buffer is visible the following cycle.
module epl_egr_rx_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = epl_egr_rx_pkg::entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_entry,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/epl_egr_rx.sv
// Egress receive buffer: checks packet framing, buffers words toward the MAC,
// returns egress credits and keeps sticky error flags plus a packet counter.
module epl_egr_rx
    import epl_egr_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    epl_egr_rx_if.slave       bus,
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              frm_err,
    output logic [31:0]       pkt_cnt,
    output state_t            dbg_state
);
    localparam int LEN_W = $clog2(DATA_W / 8);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [LEN_W-1:0]  eop_len;
        logic [DATA_W-1:0] data;
    } ent_t;

    state_t      state_q;
    state_t      state_d;
    ent_t        wr_entry;
    ent_t        head;
    logic        full;
    logic        empty;
    logic        pop;
    logic        space_ok;
    logic        push;
    logic        frm_drop;
    logic        ovf_drop;
    logic        sop_viol;
    logic [1:0]  credit_q;
    logic        ovf_q;
    logic        frm_q;
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only words that enter the buffer move the FSM; dropped words never do.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push && !bus.egr_eop) state_d = IN_PKT;
            IN_PKT:  if (push && bus.egr_eop)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = !empty && bus.mac_ready;
        space_ok = !full || pop;
        frm_drop = 1'b0;
        sop_viol = 1'b0;
        push     = 1'b0;
        ovf_drop = 1'b0;
        if (bus.egr_valid) begin
            frm_drop = (state_q == IDLE) && !bus.egr_sop;
            push     = !frm_drop && space_ok;
            ovf_drop = !frm_drop && !space_ok;
            sop_viol = push && (state_q == IN_PKT) && bus.egr_sop;
        end
    end

    always_comb begin
        wr_entry.sop     = bus.egr_sop;
        wr_entry.eop     = bus.egr_eop;
        wr_entry.eop_len = bus.egr_eop_len;
        wr_entry.data    = bus.egr_data;
    end

    epl_egr_rx_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ent_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // Overflow drops return nothing: the egress overran its credits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q  <= '0;
            ovf_q     <= 1'b0;
            frm_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            credit_q <= credit_sum(pop, frm_drop);
            if (err_clr) begin
                ovf_q <= 1'b0;
                frm_q <= 1'b0;
            end else begin
                if (ovf_drop)             ovf_q <= 1'b1;
                if (frm_drop || sop_viol) frm_q <= 1'b1;
            end
            if (pop && head.eop) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign bus.egr_credit_ret = credit_q;
    assign bus.mac_valid      = !empty;
    assign bus.mac_sop        = head.sop;
    assign bus.mac_eop        = head.eop;
    assign bus.mac_eop_len    = head.eop_len;
    assign bus.mac_data       = head.data;
    assign ovf_err            = ovf_q;
    assign frm_err            = frm_q;
    assign pkt_cnt            = pkt_cnt_q;
    assign dbg_state          = state_q;

endmodule
